// File: rtl/pc_sequencer.sv
// Program counter owner: fetch -> execute -> PC update sequencing
// with run/halt control and a retired-instruction counter.
module pc_sequencer #(
   parameter int unsigned          ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              halt_req,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   output logic              instr_valid,
   input  logic              instr_done,
   input  logic              branch_eval,
   input  logic              pc_write_enabled,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_EXEC   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic              halt_pending;
   logic              halt_pending_nxt;
   logic              retire;
   logic              take_branch;
   logic [ADDR_W-1:0] pc_nxt;

   assign take_branch = branch_eval & pc_write_enabled;
   assign retire      = (state == S_EXEC) & instr_done;

   // Both increments wrap naturally at their register width.
   assign pc_nxt = take_branch ? branch_target : pc + PC_ONE;

   always_comb begin
      state_nxt        = state;
      halt_pending_nxt = halt_pending;
      unique case (state)
         S_IDLE: begin
            if (run)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (halt_req)
               halt_pending_nxt = 1'b1;
            if (imem_ack)
               state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (halt_req)
               halt_pending_nxt = 1'b1;
            if (instr_done) begin
               if (halt_pending | halt_req) begin
                  state_nxt        = S_HALTED;
                  halt_pending_nxt = 1'b0;
               end else begin
                  state_nxt = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            // A simultaneous halt_req keeps the block parked.
            if (run & ~halt_req)
               state_nxt = S_FETCH;
         end
         default: begin
            state_nxt        = S_IDLE;
            halt_pending_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         halt_pending  <= 1'b0;
         pc            <= RESET_PC;
         retired_count <= '0;
      end else begin
         state        <= state_nxt;
         halt_pending <= halt_pending_nxt;
         if (retire) begin
            pc            <= pc_nxt;
            retired_count <= retired_count + CNT_ONE;
         end
      end
   end

   assign imem_req    = (state == S_FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == S_EXEC);
   assign busy        = (state == S_FETCH) | (state == S_EXEC);
   assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a narrow-counter twin
// shares the stimulus so counter wrap is reachable quickly.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        halt_req;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic        instr_valid;
   logic        instr_done;
   logic        branch_eval;
   logic        pc_write_enabled;
   logic [15:0] branch_target;
   logic [15:0] pc;
   logic        busy;
   logic        halted;
   logic [15:0] retired_count;

   logic        s_req;
   logic [15:0] s_addr;
   logic        s_valid;
   logic [15:0] s_pc;
   logic        s_busy;
   logic        s_halted;
   logic [3:0]  s_cnt;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .instr_valid(instr_valid), .instr_done(instr_done),
      .branch_eval(branch_eval), .pc_write_enabled(pc_write_enabled),
      .branch_target(branch_target), .pc(pc), .busy(busy),
      .halted(halted), .retired_count(retired_count)
   );

   pc_sequencer #(.CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
      .imem_req(s_req), .imem_addr(s_addr), .imem_ack(imem_ack),
      .instr_valid(s_valid), .instr_done(instr_done),
      .branch_eval(branch_eval), .pc_write_enabled(pc_write_enabled),
      .branch_target(branch_target), .pc(s_pc), .busy(s_busy),
      .halted(s_halted), .retired_count(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects FETCH; acks at once, completes the cycle after.
   task automatic do_instr(input logic be, input logic pwe,
                           input logic [15:0] tgt);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("exec_valid", {31'd0, instr_valid}, 32'd1);
      instr_done       = 1'b1;
      branch_eval      = be;
      pc_write_enabled = pwe;
      branch_target    = tgt;
      tick();
      instr_done       = 1'b0;
      branch_eval      = 1'b0;
      pc_write_enabled = 1'b0;
      branch_target    = 16'h0;
      exp_cnt++;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
      instr_done = 1'b0; branch_eval = 1'b0; pc_write_enabled = 1'b0;
      branch_target = 16'h0;
      #1;
      chk("rst_pc", {16'd0, pc}, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_cnt", {16'd0, retired_count}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("idle_halt_ign", {31'd0, halted}, 32'd0);
      chk("idle_no_req", {31'd0, imem_req}, 32'd0);

      // 1: straight-line fetch sequence
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("run_req", {31'd0, imem_req}, 32'd1);
      chk("run_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("seq_addr", {16'd0, imem_addr}, i);
         do_instr(1'b0, 1'b0, 16'h0);
      end
      chk("seq_pc", {16'd0, pc}, 32'd4);
      chk("seq_cnt", {16'd0, retired_count}, 32'd4);
      chk("seq_req", {31'd0, imem_req}, 32'd1);

      // 2: branch qualification
      do_instr(1'b0, 1'b0, 16'h0);
      chk("pc5", {16'd0, pc}, 32'd5);
      do_instr(1'b1, 1'b1, 16'h0040);
      chk("br_taken", {16'd0, imem_addr}, 32'h40);
      do_instr(1'b1, 1'b1, 16'h0005);
      do_instr(1'b1, 1'b0, 16'h0040);
      chk("br_not_taken", {16'd0, imem_addr}, 32'd6);
      do_instr(1'b1, 1'b1, 16'h0005);
      do_instr(1'b0, 1'b1, 16'h0040);
      chk("br_unqual", {16'd0, imem_addr}, 32'd6);

      // 3: delayed ack holds the request
      for (int i = 0; i < 4; i++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", {16'd0, imem_addr}, 32'd6);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
         if (i < 3) tick();
      end
      do_instr(1'b0, 1'b0, 16'h0);
      chk("after_wait_pc", {16'd0, pc}, 32'd7);

      // 4: halt during fetch, then resume
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_keeps_req", {31'd0, imem_req}, 32'd1);
      do_instr(1'b0, 1'b0, 16'h0);
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halted_busy", {31'd0, busy}, 32'd0);
      chk("halted_req", {31'd0, imem_req}, 32'd0);
      chk("halted_pc", {16'd0, pc}, 32'd8);
      instr_done = 1'b1;
      tick();
      tick();
      instr_done = 1'b0;
      chk("frozen_pc", {16'd0, pc}, 32'd8);
      run = 1'b1;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_wins", {31'd0, halted}, 32'd1);
      tick();
      run = 1'b0;
      chk("resume_req", {31'd0, imem_req}, 32'd1);
      chk("resume_addr", {16'd0, imem_addr}, 32'd8);
      chk("resume_halted", {31'd0, halted}, 32'd0);

      // 5: wrap of pc and of the narrow counter
      do_instr(1'b1, 1'b1, 16'hFFFF);
      chk("pc_ffff", {16'd0, pc}, 32'hFFFF);
      do_instr(1'b0, 1'b0, 16'h0);
      chk("pc_wrap", {16'd0, pc}, 32'h0);
      chk("cnt14", {16'd0, retired_count}, exp_cnt);
      while (exp_cnt < 15) do_instr(1'b0, 1'b0, 16'h0);
      chk("s_cnt_max", {28'd0, s_cnt}, 32'hF);
      do_instr(1'b0, 1'b0, 16'h0);
      chk("s_cnt_wrap", {28'd0, s_cnt}, 32'h0);
      chk("cnt16", {16'd0, retired_count}, 32'd16);

      // 6: asynchronous reset mid-EXEC
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_pc", {16'd0, pc}, 32'h0);
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_cnt", {16'd0, retired_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      imem_ack = 1'b1;
      instr_done = 1'b1;
      tick();
      imem_ack = 1'b0;
      instr_done = 1'b0;
      chk("stray_req", {31'd0, imem_req}, 32'd0);
      chk("stray_valid", {31'd0, instr_valid}, 32'd0);
      chk("stray_pc", {16'd0, pc}, 32'h0);
      chk("stray_cnt", {16'd0, retired_count}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
